mcycle_mul: RTL and testbench
=============================

// Module: mcycle_mul
// PURPOSE
//  Multi-cycle 32x32 shift-add multiplier. It responds to the MULWrite start request that the
//  condition logic issues for predicated MUL/UMULL/SMULL instructions.
//  Busy stalls the pipeline while the product is computed. Done and Result1/Result2 return the
//  product to the register-file write path. MulFlags feeds the flags update for MULS (N,Z only).
// PARAMETERS
//  WIDTH      32   operand width; product is 2*WIDTH bits
// PORTS
//  CLK        in   1        rising-edge clock, single clock domain
//  Reset      in   1        asynchronous, active-high reset
//  Start      in   1        = MULWrite; request, sampled only in IDLE
//  MulSigned  in   1        1: signed (SMULL), 0: unsigned (MUL/UMULL)
//  Operand1   in   WIDTH    multiplicand, sampled with accepted Start
//  Operand2   in   WIDTH    multiplier, sampled with accepted Start
//  Result1    out  WIDTH    product[WIDTH-1:0] (MUL result, RdLo)
//  Result2    out  WIDTH    product[2*WIDTH-1:WIDTH] (RdHi)
//  MulFlags   out  4        {N,Z,C,V}; N=product MSB, Z=(product==0), C=V=0
//  Busy       out  1        stall request to fetch/decode
//  Done       out  1        one-cycle pulse: results valid
// BEHAVIOUR
//  - Reset (async, any state, including mid-operation): state=IDLE. Result1=Result2=0,
//    MulFlags=0, Busy=0, Done=0. Any operation in flight is discarded and no Done is issued.
//  - States IDLE -> COMPUTE -> DONE -> IDLE.
//  - IDLE: Busy = Start (combinational, same cycle, so the issuing instruction stalls at once).
//    On Start, operands are registered. If MulSigned=1, the magnitudes |Op1| and |Op2| are
//    registered, and neg = Op1[MSB]^Op2[MSB].
//    |-2^(WIDTH-1)| = 2^(WIDTH-1) is held as an unsigned WIDTH-bit value; no overflow.
//  - COMPUTE: Busy=1. One multiplier bit is retired per cycle, LSB first:
//    acc += mcand<<i when bit i is set. The adder is WIDTH+1 bits wide and the carry is kept.
//    Iteration counter runs 0..WIDTH-1. After iteration WIDTH-1 -> DONE.
//  - DONE: Busy=0, Done=1 for exactly one cycle. Result1/Result2 hold the final product,
//    two's-complement negated when neg=1. MulFlags is updated in the same cycle.
//    DONE -> IDLE unconditionally.
//    Start during DONE is ignored; the decoder re-presents it in IDLE.
//  - Latency (feature off): Start accepted at cycle 0; Done at cycle WIDTH+1.
//    Busy is high for cycles 0..WIDTH (WIDTH+1 cycles).
//  - Result1/Result2/MulFlags hold their value from DONE until the next DONE or Reset.
//    They do not change while Busy=1.
//  - Start while in COMPUTE: ignored, no effect on the operation in flight.
//  - Operand inputs are don't-care except in the Start/IDLE cycle.
// CONFIGURATION
//  - Macro MCYCLE_MUL_EARLY_TERM_EN
//    defined:   COMPUTE -> DONE as soon as the remaining unshifted multiplier bits are all zero.
//               Final shift alignment is applied in DONE.
//               Minimum latency: Done at cycle 2 (Operand2=0 or 1).
//               Maximum latency: equal to the undefined case.
//    undefined: fixed WIDTH COMPUTE cycles regardless of operand value.
//    Results are bit-identical in both builds.
// STRUCTURE
//  - Shared package mul_pkg holds:
//    - state encoding localparams S_IDLE=2'd0, S_COMPUTE=2'd1, S_DONE=2'd2
//    - MUL_UNSIGNED=1'b0, MUL_SIGNED=1'b1
//    - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, shared with the ALU
//  - Single module; no sub-module. The negate/abs logic is a local function, not a separate block.
// TESTING
//  1. Unsigned 7*6: Start=1, Op1=7, Op2=6, MulSigned=0.
//     -> Busy high cycles 0..32. Done at cycle 33. Result1=42, Result2=0, MulFlags=4'b0000.
//  2. Signed -3*5: Op1=32'hFFFFFFFD, Op2=5, MulSigned=1.
//     -> Result2=32'hFFFFFFFF, Result1=32'hFFFFFFF1, MulFlags=4'b1000.
//  3. Corner 0x80000000*0x80000000, signed.
//     -> Result2=32'h40000000, Result1=0, MulFlags=4'b0000.
//     Same operands, unsigned: -> Result2=32'h40000000, Result1=0.
//  4. Zero product: Op1=32'h1234, Op2=0.
//     -> Result1=Result2=0, MulFlags=4'b0100.
//     With MCYCLE_MUL_EARLY_TERM_EN: Done at cycle 2.
//  5. Reset asserted at cycle 10 of a COMPUTE.
//     -> Busy=0, Done=0, Result1=Result2=0 immediately (async). No Done follows.
//     A new Start afterwards completes normally.
//  6. Start held high throughout.
//     -> second operation accepted only in the IDLE cycle after DONE.
//     Outputs are unchanged during its COMPUTE, then update at its DONE.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiplier: state encoding, signedness
// selector values and the {N,Z,C,V} flag bit positions used by the ALU.
package mul_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        COMPUTE = S_COMPUTE,
        DONE    = S_DONE
    } mul_state_e;

    localparam logic MUL_UNSIGNED = 1'b0;
    localparam logic MUL_SIGNED   = 1'b1;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mcycle_mul.sv
// Multi-cycle WIDTHxWIDTH shift-add multiplier (sign-magnitude for SMULL).
// Optional macro MCYCLE_MUL_EARLY_TERM_EN: leave COMPUTE once the remaining multiplier bits are zero.
module mcycle_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             MulSigned,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic [3:0]       MulFlags,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? ('0 - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return '0 - v;
    endfunction

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] res_q;
    logic [3:0]         flags_q;

    logic               signed_op;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_step;
    logic [2*WIDTH-1:0] prod_mag, prod_final;
    logic [3:0]         flags_final;
    logic               last_iter;

    assign signed_op = (MulSigned == MUL_SIGNED);

    // acc holds the partial product scaled by 2^(WIDTH - iterations done);
    // the WIDTH+1-bit sum keeps the carry, which shifts back into the top bit.
    // NOTE: every variable written in an always_comb gets a value on every path (defaults first), otherwise a latch is inferred.
    always_comb begin
        sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step    = {sum, acc_q[WIDTH-1:1]};
        mplier_step = mplier_q >> 1;
`ifdef MCYCLE_MUL_EARLY_TERM_EN
        prod_mag    = acc_q >> (CW'(WIDTH) - cnt_q);
        last_iter   = (cnt_q == LAST_ITER) || (mplier_step == '0);
`else
        prod_mag    = acc_q;
        last_iter   = (cnt_q == LAST_ITER);
`endif
        prod_final  = neg_q ? negate(prod_mag) : prod_mag;
        flags_final = '0;
        flags_final[FLAG_N] = prod_final[2*WIDTH-1];
        flags_final[FLAG_Z] = (prod_final == '0);
        flags_final[FLAG_C] = 1'b0;
        flags_final[FLAG_V] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = Start;
                if (Start) state_d = COMPUTE;
            end
            COMPUTE: begin
                Busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the working registers are reset along with the result registers, so no X ever reaches Result after reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (Start) begin
                    mcand_q  <= abs_val(Operand1, signed_op);
                    mplier_q <= abs_val(Operand2, signed_op);
                    neg_q    <= signed_op && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                COMPUTE: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_step;
                    cnt_q    <= cnt_q + CW'(1);
                end
                DONE: begin
                    res_q   <= prod_final;
                    flags_q <= flags_final;
                end
                default: ;
            endcase
        end
    end

    // The final product is presented directly in DONE and held from the registers afterwards.
    logic [2*WIDTH-1:0] result_view;
    assign result_view = (state_q == DONE) ? prod_final : res_q;
    assign Result1     = result_view[WIDTH-1:0];
    assign Result2     = result_view[2*WIDTH-1:WIDTH];
    assign MulFlags    = (state_q == DONE) ? flags_final : flags_q;

endmodule

// File: tb/tb_mcycle_mul.sv
// Self-checking bench for mcycle_mul: vector table, random operands against an
// arithmetic reference, plus reset-mid-operation and held-Start sequences.
module tb_mcycle_mul;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        MulSigned;
    logic [31:0] Operand1, Operand2;
    logic [31:0] Result1, Result2;
    logic [3:0]  MulFlags;
    logic        Busy, Done;

    int n_checks = 0;
    int n_fail   = 0;

    mcycle_mul #(.WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .MulSigned(MulSigned),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .MulFlags(MulFlags),
        .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [3:0] model_flags(input logic [63:0] p);
        return {p[63], p == 64'd0, 2'b00};
    endfunction

    // Cycle (counted from the Start-accept cycle 0) in which Done is expected.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
`ifdef MCYCLE_MUL_EARLY_TERM_EN
        logic [31:0] m;
        int h;
        m = (s && b[31]) ? (32'd0 - b) : b;
        h = -1;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
        return (h < 0) ? 2 : h + 2;
`else
        return 33;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_p, input logic [3:0] exp_f, input string tag);
        logic [63:0] prev;
        logic [3:0]  prev_f;
        bit          seen, held_ok, busy_ok;
        int          lat;
        prev    = {Result2, Result1};
        prev_f  = MulFlags;
        @(negedge CLK);
        Start = 1'b1; Operand1 = a; Operand2 = b; MulSigned = s;
        #1;
        check({tag, " busy_at_start"}, 64'(Busy), 64'd1);
        @(posedge CLK);
        #1;
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; MulSigned = 1'($urandom);
        seen = 0; held_ok = 1; busy_ok = 1; lat = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge CLK);
            if (Done) begin
                seen = 1;
                lat  = k;
            end else begin
                if (!Busy) busy_ok = 0;
                if ({Result2, Result1} !== prev || MulFlags !== prev_f) held_ok = 0;
            end
        end
        check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, " held_during"}, 64'(held_ok), 64'd1);
        check({tag, " done_cycle"}, 64'(lat), 64'(exp_lat(b, s)));
        check({tag, " busy_at_done"}, 64'(Busy), 64'd0);
        check({tag, " result"}, {Result2, Result1}, exp_p);
        check({tag, " flags"}, 64'(MulFlags), 64'(exp_f));
        @(negedge CLK);
        check({tag, " done_pulse"}, 64'({Done, Busy}), 64'd0);
        check({tag, " result_held"}, {Result2, Result1}, exp_p);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] p;
        bit          no_done, ok;
        int          k1, k2;

        vecs[0] = '{32'd7,         32'd6,         1'b0, 32'd42,        32'd0,         4'b0000};
        vecs[1] = '{32'hFFFFFFFD,  32'd5,         1'b1, 32'hFFFFFFF1,  32'hFFFFFFFF,  4'b1000};
        vecs[2] = '{32'h80000000,  32'h80000000,  1'b1, 32'd0,         32'h40000000,  4'b0000};
        vecs[3] = '{32'h80000000,  32'h80000000,  1'b0, 32'd0,         32'h40000000,  4'b0000};
        vecs[4] = '{32'h00001234,  32'd0,         1'b0, 32'd0,         32'd0,         4'b0100};
        vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h00000001,  32'hFFFFFFFE,  4'b1000};
        vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'h00000001,  32'd0,         4'b0000};
        vecs[7] = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 32'h80000000,  32'hC0000000,  4'b1000};
        vecs[8] = '{32'd1,         32'd1,         1'b0, 32'd1,         32'd0,         4'b0000};
        vecs[9] = '{32'hFFFFFFFB,  32'd0,         1'b1, 32'd0,         32'd0,         4'b0100};

        Reset = 1'b1; Start = 1'b0; MulSigned = 1'b0; Operand1 = '0; Operand2 = '0;
        #1;
        check("reset_outputs", {Result2, Result1}, 64'd0);
        check("reset_ctrl", 64'({MulFlags, Busy, Done}), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].hi, vecs[i].lo}, vecs[i].fl,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 4 == 0) rb = -rb;
            rs = 1'($urandom);
            p  = model(ra, rb, rs);
            run_op(ra, rb, rs, p, model_flags(p), $sformatf("rnd%0d", i));
        end

        // Reset in cycle 10 of a long operation: outputs clear at once, no Done follows.
        run_op(32'd7, 32'd6, 1'b0, 64'd42, 4'b0000, "pre_reset");
        @(negedge CLK);
        Start = 1'b1; Operand1 = 32'h00010003; Operand2 = 32'hFFFF0000; MulSigned = 1'b0;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check("midreset_ctrl", 64'({Busy, Done}), 64'd0);
        check("midreset_result", {Result2, Result1}, 64'd0);
        check("midreset_flags", 64'(MulFlags), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        no_done = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Done || Busy) no_done = 0;
        end
        check("midreset_no_done", 64'(no_done), 64'd1);
        p = model(32'h00010003, 32'hFFFF0000, 1'b0);
        run_op(32'h00010003, 32'hFFFF0000, 1'b0, p, model_flags(p), "post_reset");

        // Start held high: op A, then op B accepted only in the IDLE cycle after A's DONE.
        @(negedge CLK);
        Start = 1'b1; Operand1 = 32'h00001001; Operand2 = 32'h80000003; MulSigned = 1'b0;
        @(posedge CLK);
        #1;
        Operand1 = 32'hFFFFFFF9; Operand2 = 32'h00000011; MulSigned = 1'b1;
        k1 = 0; k2 = 0; ok = 1;
        for (int k = 1; k <= 100 && k2 == 0; k++) begin
            @(negedge CLK);
            if (Done && k1 == 0) begin
                k1 = k;
                check("held_a_result", {Result2, Result1}, model(32'h00001001, 32'h80000003, 1'b0));
            end else if (k1 != 0 && k == k1 + 1) begin
                check("held_b_accept_busy", 64'(Busy), 64'd1);
            end else if (Done) begin
                k2 = k;
            end else if (k1 != 0 && {Result2, Result1} !== model(32'h00001001, 32'h80000003, 1'b0)) begin
                ok = 0;
            end
        end
        Start = 1'b0;
        check("held_a_cycle", 64'(k1), 64'(exp_lat(32'h80000003, 1'b0)));
        check("held_outputs_stable", 64'(ok), 64'd1);
        check("held_b_cycle", 64'(k2), 64'(k1 + 1 + exp_lat(32'h00000011, 1'b1)));
        p = model(32'hFFFFFFF9, 32'h00000011, 1'b1);
        check("held_b_result", {Result2, Result1}, p);
        check("held_b_flags", 64'(MulFlags), 64'(model_flags(p)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
